// File: rtl/spi_pix_pkg.sv
// ---------------------------------------------------------------------------
// spi_pix_pkg
//   Shared definitions for the pixel SPI transmit lane: frame state encoding,
//   default timing constants (also used by the receive lane) and the frame
//   width of one pixel write (address followed by luma).
// ---------------------------------------------------------------------------
package spi_pix_pkg;

   localparam int unsigned DEF_CLK_DIV  = 4;
   localparam int unsigned DEF_CS_SETUP = 2;
   localparam int unsigned DEF_CS_HOLD  = 2;
   localparam int unsigned DEF_IDLE_GAP = 2;
   localparam int unsigned DEF_ADDR_W   = 16;
   localparam int unsigned DEF_DATA_W   = 12;

   localparam int unsigned FRAME_BITS = DEF_ADDR_W + DEF_DATA_W;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_e;

   // Number of Cclk cycles CS_n stays low for one frame.
   function automatic int unsigned cs_low_cycles(input int unsigned div,
                                                 input int unsigned setup,
                                                 input int unsigned hold,
                                                 input int unsigned bits);
      return setup + 2 * div * bits + hold;
   endfunction

endpackage

// File: rtl/spi_pix_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// spi_bit_timer
//   SCLK phase generator. While enabled it produces SCLK low for CLK_DIV
//   cycles, then high for CLK_DIV cycles, repeating. Outside of enable the
//   phase counter is held at zero and SCLK is held low.
//
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   en_i    run the timer (frame is in the shift phase)
//   sclk_o  registered SCLK level
//   rise_o  strobe: SCLK goes high at the coming clock edge
//   fall_o  strobe: SCLK goes low at the coming clock edge
// ---------------------------------------------------------------------------
module spi_bit_timer #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       sclk_q, sclk_d;
   logic       half_end;

   // Counter covers one half-period so CLK_DIV up to 255 fits in 8 bits.
   assign half_end = en_i && (cnt_q == DIV_M1);

   always_comb begin
      cnt_d  = '0;
      sclk_d = 1'b0;
      if (en_i) begin
         cnt_d  = half_end ? '0 : cnt_q + 8'd1;
         sclk_d = half_end ? ~sclk_q : sclk_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
   assign rise_o = half_end && !sclk_q;
   assign fall_o = half_end &&  sclk_q;

endmodule

// File: rtl/spi_pix_tx.sv
// ---------------------------------------------------------------------------
// spi_pix_tx
//   Single-lane SPI master (mode 0) sending one pixel write per chip-select
//   frame: {s_addr, s_data}, MSB first. MISO is captured during the frame
//   and presented as rx_word with a one-cycle rx_valid at the end of HOLD.
//
//   Cclk      system clock
//   rstn      asynchronous active-low reset (aborts any frame in flight)
//   s_valid   pixel word valid
//   s_ready   accepting a word (IDLE only)
//   s_addr    line-buffer address
//   s_data    luma sample
//   SCLK      SPI clock, idle low
//   MOSI      SPI data out
//   CS_n      chip select, active low
//   MISO      SPI data in
//   rx_word   bits captured on MISO in the last completed frame
//   rx_valid  one-cycle pulse when rx_word updates
//   busy      high from accept until the end of the inter-frame gap
// ---------------------------------------------------------------------------
module spi_pix_tx
   import spi_pix_pkg::*;
#(
   parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
   parameter int unsigned CS_SETUP = DEF_CS_SETUP,
   parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
   parameter int unsigned IDLE_GAP = DEF_IDLE_GAP,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W
) (
   input  logic                     Cclk,
   input  logic                     rstn,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [ADDR_W-1:0]        s_addr,
   input  logic [DATA_W-1:0]        s_data,
   output logic                     SCLK,
   output logic                     MOSI,
   output logic                     CS_n,
   input  logic                     MISO,
   output logic [ADDR_W+DATA_W-1:0] rx_word,
   output logic                     rx_valid,
   output logic                     busy
);

   localparam int unsigned N   = ADDR_W + DATA_W;
   localparam int unsigned BCW = $clog2(N + 1);

   localparam logic [BCW-1:0] LAST_BIT = BCW'(N - 1);
   localparam logic [7:0]     SETUP_M1 = 8'(CS_SETUP - 1);
   localparam logic [7:0]     HOLD_M1  = 8'(CS_HOLD - 1);
   localparam logic [7:0]     GAP_M1   = 8'(IDLE_GAP - 1);

   state_e           state_q;
   logic             s_ready_q;
   logic             cs_n_q;
   logic             mosi_q;
   logic             busy_q;
   logic             rx_valid_q;
   logic [N-1:0]     rx_word_q;
   logic [N-1:0]     tx_sh_q;
   logic [N-1:0]     rx_sh_q;
   logic [BCW-1:0]   bit_q;
   logic [7:0]       dly_q;

   logic             sclk;
   logic             rise;
   logic             fall;

   spi_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_bit_timer (
      .clk_i  (Cclk),
      .rst_ni (rstn),
      .en_i   (state_q == SHIFT),
      .sclk_o (sclk),
      .rise_o (rise),
      .fall_o (fall)
   );

   always_ff @(posedge Cclk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         s_ready_q  <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_word_q  <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         bit_q      <= '0;
         dly_q      <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (s_valid && s_ready_q) begin
                  state_q   <= SETUP;
                  s_ready_q <= 1'b0;
                  busy_q    <= 1'b1;
                  cs_n_q    <= 1'b0;
                  tx_sh_q   <= {s_addr, s_data};
                  mosi_q    <= s_addr[ADDR_W-1];
                  rx_sh_q   <= '0;
                  bit_q     <= '0;
                  dly_q     <= SETUP_M1;
               end else begin
                  s_ready_q <= 1'b1;
               end
            end

            SETUP: begin
               if (dly_q == 8'd0) begin
                  state_q <= SHIFT;
               end else begin
                  dly_q <= dly_q - 8'd1;
               end
            end

            SHIFT: begin
               if (rise) begin
                  rx_sh_q <= {rx_sh_q[N-2:0], MISO};
               end
               // MOSI advances on the same edge SCLK falls, so it is stable
               // for the whole low phase ahead of the next rise.
               if (fall) begin
                  tx_sh_q <= {tx_sh_q[N-2:0], 1'b0};
                  mosi_q  <= tx_sh_q[N-2];
                  if (bit_q == LAST_BIT) begin
                     state_q <= HOLD;
                     bit_q   <= '0;
                     dly_q   <= HOLD_M1;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end
            end

            HOLD: begin
               if (dly_q == 8'd0) begin
                  state_q    <= GAP;
                  cs_n_q     <= 1'b1;
                  rx_word_q  <= rx_sh_q;
                  rx_valid_q <= 1'b1;
                  dly_q      <= GAP_M1;
               end else begin
                  dly_q <= dly_q - 8'd1;
               end
            end

            GAP: begin
               if (dly_q == 8'd0) begin
                  state_q   <= IDLE;
                  s_ready_q <= 1'b1;
                  busy_q    <= 1'b0;
               end else begin
                  dly_q <= dly_q - 8'd1;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_ready  = s_ready_q;
   assign SCLK     = sclk;
   assign MOSI     = mosi_q;
   assign CS_n     = cs_n_q;
   assign rx_word  = rx_word_q;
   assign rx_valid = rx_valid_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_spi_pix_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_pix_tx
//   Directed bench for spi_pix_tx. Instance A uses default timing, instance B
//   uses the fastest legal timing (CLK_DIV=2, 1-cycle setup/hold/gap).
// ---------------------------------------------------------------------------
module tb_spi_pix_tx;
   import spi_pix_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        miso;

   logic        s_valid_a, s_ready_a, sclk_a, mosi_a, cs_n_a, rx_valid_a, busy_a;
   logic [15:0] s_addr_a;
   logic [11:0] s_data_a;
   logic [27:0] rx_word_a;

   logic        s_valid_b, s_ready_b, sclk_b, mosi_b, cs_n_b, rx_valid_b, busy_b;
   logic [15:0] s_addr_b;
   logic [11:0] s_data_b;
   logic [27:0] rx_word_b;

   int n_checks = 0;
   int n_fail   = 0;

   // Receiver-side line memory model.
   logic [11:0] mem [logic [15:0]];

   always #5 clk = ~clk;

   spi_pix_tx #(
      .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .IDLE_GAP(2), .ADDR_W(16), .DATA_W(12)
   ) dut_a (
      .Cclk(clk), .rstn(rstn), .s_valid(s_valid_a), .s_ready(s_ready_a),
      .s_addr(s_addr_a), .s_data(s_data_a), .SCLK(sclk_a), .MOSI(mosi_a),
      .CS_n(cs_n_a), .MISO(miso), .rx_word(rx_word_a), .rx_valid(rx_valid_a),
      .busy(busy_a)
   );

   spi_pix_tx #(
      .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .IDLE_GAP(1), .ADDR_W(16), .DATA_W(12)
   ) dut_b (
      .Cclk(clk), .rstn(rstn), .s_valid(s_valid_b), .s_ready(s_ready_b),
      .s_addr(s_addr_b), .s_data(s_data_b), .SCLK(sclk_b), .MOSI(mosi_b),
      .CS_n(cs_n_b), .MISO(miso), .rx_word(rx_word_b), .rx_valid(rx_valid_b),
      .busy(busy_b)
   );

   // Waits for s_ready, presents one word for a single cycle, returns on the
   // negedge right after the accepting edge.
   task automatic start_word(input bit sel, input logic [15:0] a,
                             input logic [11:0] d, output bit timeout);
      timeout = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if ((sel ? s_ready_b : s_ready_a) === 1'b1) begin
            timeout = 1'b0;
            break;
         end
         @(negedge clk);
      end
      if (!timeout) begin
         if (sel) begin
            s_valid_b = 1'b1; s_addr_b = a; s_data_b = d;
         end else begin
            s_valid_a = 1'b1; s_addr_a = a; s_data_a = d;
         end
         @(negedge clk);
         s_valid_a = 1'b0;
         s_valid_b = 1'b0;
      end
   endtask

   // Follows one frame from the current negedge: counts CS_n low cycles and
   // SCLK rises, captures MOSI at each rise, measures phase lengths, drives
   // MISO from pat (MSB first, updated at each SCLK fall) and counts rx_valid.
   task automatic observe(input bit sel, input logic [27:0] pat,
                          output int cs_low, output int rises,
                          output logic [27:0] bits, output int rxv_total,
                          output bit rxv_at_end, output int hi_min,
                          output int hi_max, output int lo_min,
                          output int lo_max, output int glitch,
                          output bit timeout);
      logic c, s, m, rv, prev_s, started, seen_fall, mosi_at_rise;
      int   hi_run, lo_run, post;
      cs_low = 0; rises = 0; bits = '0; rxv_total = 0; rxv_at_end = 1'b0;
      hi_min = 9999; hi_max = 0; lo_min = 9999; lo_max = 0; glitch = 0;
      timeout = 1'b1; prev_s = 1'b0; started = 1'b0; seen_fall = 1'b0;
      mosi_at_rise = 1'b0; hi_run = 0; lo_run = 0; post = -1;
      for (int cyc = 0; cyc < 800; cyc++) begin
         c  = sel ? cs_n_b     : cs_n_a;
         s  = sel ? sclk_b     : sclk_a;
         m  = sel ? mosi_b     : mosi_a;
         rv = sel ? rx_valid_b : rx_valid_a;
         if (rv) rxv_total++;
         if (post >= 0) begin
            post++;
            if (post > 3) begin
               timeout = 1'b0;
               break;
            end
         end else if (started && c) begin
            post = 0;
            rxv_at_end = rv;
         end else if (!c) begin
            if (!started) begin
               started = 1'b1;
               miso = pat[27];
            end
            cs_low++;
            if (s && !prev_s) begin
               if (seen_fall) begin
                  if (lo_run < lo_min) lo_min = lo_run;
                  if (lo_run > lo_max) lo_max = lo_run;
               end
               rises++;
               bits = {bits[26:0], m};
               mosi_at_rise = m;
               hi_run = 0;
            end
            if (s) begin
               hi_run++;
               if (m !== mosi_at_rise) glitch++;
            end
            if (!s && prev_s) begin
               if (hi_run < hi_min) hi_min = hi_run;
               if (hi_run > hi_max) hi_max = hi_run;
               seen_fall = 1'b1;
               lo_run = 0;
               if (rises < 28) miso = pat[27 - rises];
            end
            if (!s) lo_run++;
            prev_s = s;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0; miso = 1'b0;
      s_valid_a = 1'b0; s_addr_a = '0; s_data_a = '0;
      s_valid_b = 1'b0; s_addr_b = '0; s_data_b = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({s_ready_a, sclk_a, mosi_a, cs_n_a, rx_valid_a, busy_a} !== 6'b000100) begin
         n_fail++;
         $display("FAIL reset_outs: got rdy,sclk,mosi,csn,rxv,busy=%b want 000100",
                  {s_ready_a, sclk_a, mosi_a, cs_n_a, rx_valid_a, busy_a});
      end
      n_checks++;
      if (rx_word_a !== 28'h0) begin
         n_fail++;
         $display("FAIL reset_rx_word: got %h want 0000000", rx_word_a);
      end
      rstn = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({s_ready_a, s_ready_b} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_ready_rise: got %b want 11", {s_ready_a, s_ready_b});
      end
   endtask

   task automatic test_single();
      bit to, ob_to, rxe;
      int csl, rs, rxt, hmin, hmax, lmin, lmax, gl;
      logic [27:0] bits;
      start_word(1'b0, 16'h95FF, 12'hABC, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL single_accept: got timeout want accept"); end
      n_checks++;
      if ({s_ready_a, busy_a, cs_n_a, mosi_a} !== 4'b0101) begin
         n_fail++;
         $display("FAIL single_after_accept: got rdy,busy,csn,mosi=%b want 0101",
                  {s_ready_a, busy_a, cs_n_a, mosi_a});
      end
      observe(1'b0, 28'h0, csl, rs, bits, rxt, rxe, hmin, hmax, lmin, lmax, gl, ob_to);
      if (rs == 28) mem[bits[27:12]] = bits[11:0];
      n_checks++;
      if (ob_to) begin n_fail++; $display("FAIL single_frame_end: got timeout want CS_n rise"); end
      n_checks++;
      if (csl != 228) begin n_fail++; $display("FAIL single_cs_low: got %0d want 228", csl); end
      n_checks++;
      if (rs != 28) begin n_fail++; $display("FAIL single_rises: got %0d want 28", rs); end
      n_checks++;
      if (bits !== 28'h95FFABC) begin n_fail++; $display("FAIL single_mosi: got %h want 95ffabc", bits); end
      n_checks++;
      if (gl != 0) begin n_fail++; $display("FAIL single_mosi_stable: got %0d changes want 0", gl); end
      n_checks++;
      if ({hmin, hmax, lmin, lmax} !== {32'd4, 32'd4, 32'd4, 32'd4}) begin
         n_fail++;
         $display("FAIL single_phases: got hi %0d..%0d lo %0d..%0d want 4", hmin, hmax, lmin, lmax);
      end
      n_checks++;
      if (!mem.exists(16'h95FF) || mem[16'h95FF] !== 12'hABC) begin
         n_fail++;
         $display("FAIL single_mem_write: got %h want abc", mem.exists(16'h95FF) ? mem[16'h95FF] : 12'hxxx);
      end
   endtask

   task automatic test_miso();
      bit to, ob_to, rxe;
      int csl, rs, rxt, hmin, hmax, lmin, lmax, gl;
      logic [27:0] bits;
      start_word(1'b0, 16'h1234, 12'h567, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL miso_accept: got timeout want accept"); end
      observe(1'b0, 28'hA5A5A5A, csl, rs, bits, rxt, rxe, hmin, hmax, lmin, lmax, gl, ob_to);
      n_checks++;
      if (rx_word_a !== 28'hA5A5A5A) begin n_fail++; $display("FAIL miso_rx_word: got %h want a5a5a5a", rx_word_a); end
      n_checks++;
      if (rxt != 1) begin n_fail++; $display("FAIL miso_rx_valid_count: got %0d want 1", rxt); end
      n_checks++;
      if (rxe !== 1'b1) begin n_fail++; $display("FAIL miso_rx_valid_timing: got %b want 1 at CS_n rise", rxe); end
      n_checks++;
      if (bits !== 28'h1234567) begin n_fail++; $display("FAIL miso_mosi: got %h want 1234567", bits); end
   endtask

   task automatic test_back_to_back();
      logic [27:0] w [3];
      logic [27:0] rx_w [3];
      int acc_cyc [3];
      int acc, got, k, ready_cnt;
      logic upd, prev_c, prev_s;
      logic [27:0] cur;
      w[0] = 28'h0001111; w[1] = 28'h9000222; w[2] = 28'h95FFFFF;
      rx_w[0] = '0; rx_w[1] = '0; rx_w[2] = '0;
      acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
      acc = 0; got = 0; k = 1; ready_cnt = 0; upd = 1'b0;
      prev_c = 1'b1; prev_s = 1'b0; cur = '0;
      s_valid_a = 1'b1;
      {s_addr_a, s_data_a} = w[0];
      for (int cyc = 0; cyc < 1200; cyc++) begin
         if (upd) begin
            if (k < 3) {s_addr_a, s_data_a} = w[k];
            else s_valid_a = 1'b0;
            k++;
            upd = 1'b0;
         end
         if (s_ready_a && acc < 3) ready_cnt++;
         if (s_valid_a && s_ready_a && acc < 3) begin
            acc_cyc[acc] = cyc;
            acc++;
            upd = 1'b1;
         end
         if (!cs_n_a && sclk_a && !prev_s) cur = {cur[26:0], mosi_a};
         if (cs_n_a && !prev_c && got < 3) begin
            rx_w[got] = cur;
            got++;
         end
         prev_c = cs_n_a;
         prev_s = sclk_a;
         if (got == 3) break;
         @(negedge clk);
      end
      s_valid_a = 1'b0;
      n_checks++;
      if (acc != 3 || got != 3) begin
         n_fail++;
         $display("FAIL b2b_complete: got %0d accepts %0d frames want 3 and 3", acc, got);
      end
      n_checks++;
      if (acc_cyc[1] - acc_cyc[0] != 231) begin
         n_fail++; $display("FAIL b2b_spacing_1: got %0d want 231", acc_cyc[1] - acc_cyc[0]);
      end
      n_checks++;
      if (acc_cyc[2] - acc_cyc[1] != 231) begin
         n_fail++; $display("FAIL b2b_spacing_2: got %0d want 231", acc_cyc[2] - acc_cyc[1]);
      end
      n_checks++;
      if (ready_cnt != 3) begin
         n_fail++; $display("FAIL b2b_ready_cycles: got %0d want 3", ready_cnt);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (rx_w[i] !== w[i]) begin
            n_fail++; $display("FAIL b2b_word_%0d: got %h want %h", i, rx_w[i], w[i]);
         end
      end
   endtask

   task automatic test_fast();
      bit to, ob_to, rxe;
      int csl, rs, rxt, hmin, hmax, lmin, lmax, gl;
      logic [27:0] bits;
      start_word(1'b1, 16'h0F0F, 12'h3C5, to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL fast_accept: got timeout want accept"); end
      observe(1'b1, 28'h0, csl, rs, bits, rxt, rxe, hmin, hmax, lmin, lmax, gl, ob_to);
      n_checks++;
      if (csl != 114) begin n_fail++; $display("FAIL fast_cs_low: got %0d want 114", csl); end
      n_checks++;
      if (hmin != 2 || hmax != 2) begin n_fail++; $display("FAIL fast_sclk_high: got %0d..%0d want 2", hmin, hmax); end
      n_checks++;
      if (lmin != 2 || lmax != 2) begin n_fail++; $display("FAIL fast_sclk_low: got %0d..%0d want 2", lmin, lmax); end
      n_checks++;
      if (rs != 28 || bits !== 28'h0F0F3C5) begin
         n_fail++; $display("FAIL fast_mosi: got %0d rises data %h want 28 rises data 0f0f3c5", rs, bits);
      end
   endtask

   task automatic test_abort();
      bit to, ob_to, rxe;
      int csl, rs, rxt, hmin, hmax, lmin, lmax, gl, rises, bad_rxv, bad_cs;
      logic [27:0] bits;
      logic prev_s;
      start_word(1'b0, 16'h2222, 12'h111, to);
      rises = 0; prev_s = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (sclk_a && !prev_s) rises++;
         prev_s = sclk_a;
         if (rises == 10) break;
         @(negedge clk);
      end
      n_checks++;
      if (to || rises != 10) begin n_fail++; $display("FAIL abort_reach_bit10: got %0d rises want 10", rises); end
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if ({cs_n_a, sclk_a} !== 2'b10) begin
         n_fail++; $display("FAIL abort_async: got csn,sclk=%b want 10", {cs_n_a, sclk_a});
      end
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      n_checks++;
      if (s_ready_a !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", s_ready_a); end
      bad_rxv = 0; bad_cs = 0;
      for (int i = 0; i < 250; i++) begin
         if (rx_valid_a !== 1'b0) bad_rxv++;
         if (cs_n_a !== 1'b1) bad_cs++;
         @(negedge clk);
      end
      n_checks++;
      if (bad_rxv != 0 || bad_cs != 0) begin
         n_fail++; $display("FAIL abort_frame_lost: got %0d rx_valid %0d cs low want 0 and 0", bad_rxv, bad_cs);
      end
      start_word(1'b0, 16'h8001, 12'h801, to);
      observe(1'b0, 28'h5A5A5A5, csl, rs, bits, rxt, rxe, hmin, hmax, lmin, lmax, gl, ob_to);
      n_checks++;
      if (to || csl != 228 || bits !== 28'h8001801) begin
         n_fail++; $display("FAIL abort_next_frame: got cs %0d data %h want 228 and 8001801", csl, bits);
      end
      n_checks++;
      if (rx_word_a !== 28'h5A5A5A5 || rxt != 1) begin
         n_fail++; $display("FAIL abort_next_rx: got %h x%0d want 5a5a5a5 x1", rx_word_a, rxt);
      end
   endtask

   task automatic test_gap_ignore();
      bit to, found;
      int bad_cs;
      start_word(1'b0, 16'h0BEE, 12'h123, to);
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (cs_n_a === 1'b1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_checks++;
      if (to || !found) begin n_fail++; $display("FAIL gap_reach: got timeout want GAP"); end
      s_valid_a = 1'b1; s_addr_a = 16'hDEAD; s_data_a = 12'h999;
      @(negedge clk);
      s_valid_a = 1'b0;
      n_checks++;
      if ({s_ready_a, busy_a, cs_n_a, sclk_a} !== 4'b0110) begin
         n_fail++; $display("FAIL gap_during: got rdy,busy,csn,sclk=%b want 0110",
                            {s_ready_a, busy_a, cs_n_a, sclk_a});
      end
      @(negedge clk);
      n_checks++;
      if ({s_ready_a, busy_a, cs_n_a} !== 3'b101) begin
         n_fail++; $display("FAIL gap_to_idle: got rdy,busy,csn=%b want 101", {s_ready_a, busy_a, cs_n_a});
      end
      bad_cs = 0;
      for (int i = 0; i < 250; i++) begin
         if (cs_n_a !== 1'b1 || busy_a !== 1'b0) bad_cs++;
         @(negedge clk);
      end
      n_checks++;
      if (bad_cs != 0) begin n_fail++; $display("FAIL gap_not_latched: got %0d active cycles want 0", bad_cs); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_miso();
      test_back_to_back();
      test_fast();
      test_abort();
      test_gap_ignore();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion want finish within 40000 cycles");
      $fatal(1);
   end

endmodule

// File: doc/spi_pix_tx.md
Name: spi_pix_tx

Overview:
Single-lane SPI master that serialises one pixel write (16-bit line-buffer address plus 12-bit luma) per chip-select frame toward the SPI receive lane feeding the display line memory. Four instances drive SCLK[3:0]/MOSI[3:0]/CS_n[3:0] of the receive side, one per memory bank. Pixel words arrive from the camera/packing logic over a valid/ready handshake. MISO is shifted in and returned as an optional status word.

Parameters:
CLK_DIV, 4, Cclk cycles per SCLK half-period (legal 2..255)
CS_SETUP, 2, Cclk cycles CS_n low before the first SCLK rise (>=1)
CS_HOLD, 2, Cclk cycles CS_n held low after the last SCLK fall (>=1)
IDLE_GAP, 2, Cclk cycles CS_n high between frames (>=1)
ADDR_W, 16, address field width
DATA_W, 12, data field width

Ports:
Cclk  in  1  system clock
rstn  in  1  asynchronous active-low reset
s_valid  in  1  pixel word valid
s_ready  out  1  block can accept a word
s_addr  in  ADDR_W  memory address (0..38399 used)
s_data  in  DATA_W  pixel data
SCLK  out  1  SPI clock, idle low (mode 0)
MOSI  out  1  SPI data out, MSB first
CS_n  out  1  chip select, active low
MISO  in  1  SPI data in
rx_word  out  ADDR_W+DATA_W  bits captured on MISO in the last frame
rx_valid  out  1  one-cycle pulse when rx_word updates
busy  out  1  high from accept until the end of IDLE_GAP

Behaviour:
- Single clock Cclk; reset is asynchronous and active-low (rstn). All outputs registered.
- Reset values: state IDLE, s_ready=0, SCLK=0, MOSI=0, CS_n=1, rx_word=0, rx_valid=0, busy=0. Assertion mid-frame aborts immediately: CS_n high, SCLK low, frame lost, no rx_valid.
- s_ready rises in the first cycle after reset release and is 1 only in IDLE. Accept occurs when s_valid&&s_ready on a rising edge. The shift register then loads {s_addr,s_data} (N=ADDR_W+DATA_W=28 bits), s_ready drops and busy rises.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- SETUP: entered on accept. CS_n=0, MOSI=bit N-1, SCLK=0. Lasts CS_SETUP cycles.
- SHIFT: N bit periods of 2*CLK_DIV cycles each, SCLK low for CLK_DIV cycles then high for CLK_DIV cycles.
  - MOSI changes only in the cycle SCLK falls, and is stable across every rise.
  - MISO is sampled into the receive shift register in the cycle SCLK rises.
  - After the N-th high phase, SCLK returns low and the block enters HOLD. No extra edge is generated.
- HOLD: CS_n=0, SCLK=0 for CS_HOLD cycles. On exit, rx_word is loaded with the captured bits (first bit in the MSB) and rx_valid pulses for 1 cycle.
- GAP: CS_n=1 for IDLE_GAP cycles, then IDLE with s_ready=1.
- CS_n low time is exactly CS_SETUP + 2*CLK_DIV*N + CS_HOLD cycles: 228 at defaults. Minimum accept-to-accept spacing is that plus IDLE_GAP + 1: 231 at defaults.
- s_valid asserted while not ready is ignored and is not latched. Input words are not buffered; the upstream holds the word.
- Counters: bit counter of ceil(log2(N+1)) bits, and phase counter of 8 bits. Both wrap only under state control and never free-run in IDLE.

Decomposition:
- Package spi_pix_pkg holds the state enum (IDLE, SETUP, SHIFT, HOLD, GAP), the FRAME_BITS = ADDR_W+DATA_W constant, and the default timing constants shared with the receive lane.
- Sub-module spi_bit_timer is the natural split. It is the phase counter that generates the SCLK level plus rise and fall strobes from CLK_DIV, enabled only in SHIFT.

Test Plan:
- Reset, then a single word addr=16'h95FF, data=12'hABC -> CS_n low for 228 cycles, 28 SCLK rises, MOSI bits equal 28'h95FFABC MSB first, and the receiver model writes mem[16'h95FF]=12'hABC.
- MISO driven with the pattern 28'hA5A5A5A -> rx_word=28'hA5A5A5A and a single rx_valid pulse in the cycle HOLD ends.
- Back-to-back s_valid held high with 3 words -> each accepted exactly 231 cycles apart, s_ready low in between, and no word duplicated or dropped.
- CLK_DIV=2, CS_SETUP=1, CS_HOLD=1, IDLE_GAP=1 -> CS_n low exactly 114 cycles and SCLK high/low phases exactly 2 cycles.
- rstn pulsed low at bit 10 of SHIFT -> CS_n=1 and SCLK=0 asynchronously, no rx_valid, and s_ready=1 one cycle after release. The next frame is bit-exact.
- s_valid toggled for 1 cycle during GAP -> ignored, and the state and outputs are unchanged.
